tcu_sequencer: RTL

TCU_SEQUENCER -- requirements
Module: tcu_sequencer

---
 rtl/tcu_pkg.sv | 20 ++
 rtl/tcu_nmi_latch.sv | 41 ++++
 rtl/tcu_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tcu_pkg.sv
// Shared types for the T-state sequencer: state enum and the all-ones power-up T-state.
// Combinational helpers only; no latency, no backpressure.
package tcu_pkg;

    typedef enum logic [1:0] {
        ST_PRE = 2'd0,
        ST_RUN = 2'd1,
        ST_JAM = 2'd2
    } tcu_state_e;

    localparam int TCU_WIDTH_DEFAULT = 4;

    // All-ones T-state for a counter of the given width (the value shown before the first enabled cycle).
    function automatic logic [31:0] tcu_reset_value(input int unsigned width);
        return 32'((64'd1 << width) - 64'd1);
    endfunction

    localparam logic [31:0] TCU_RESET_DEFAULT = tcu_reset_value(TCU_WIDTH_DEFAULT);

endpackage

// File: rtl/tcu_nmi_latch.sv
// NMI falling-edge detector with a pending latch; edge registers one cycle after it is sampled.
// No backpressure: an edge arriving with consume still leaves the request pending.
module tcu_nmi_latch (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic nmi_n,
    input  logic consume,
    output logic pending
);

    logic nmi_prev_q;
    logic nmi_prev_d;
    logic pending_q;
    logic pending_d;
    logic fall;

    always_comb begin
        nmi_prev_d = nmi_prev_q;
        pending_d  = pending_q;
        fall       = 1'b0;
        if (enable) begin
            nmi_prev_d = nmi_n;
            fall       = nmi_prev_q & ~nmi_n;
            pending_d  = fall | (pending_q & ~consume);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nmi_prev_q <= 1'b1;
            pending_q  <= 1'b0;
        end else begin
            nmi_prev_q <= nmi_prev_d;
            pending_q  <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/tcu_sequencer.sv
// 6502-style T-state sequencer (PRE/RUN/JAM) with NMI/IRQ service flags; T-state updates one enabled cycle after decode.
// RDY stalls read cycles only (o_stall combinational); optional cycle/instruction counters under TCU_SEQUENCER_COUNTERS_EN.
module tcu_sequencer
    import tcu_pkg::*;
#(
    parameter int TCU_WIDTH = 4,
    parameter int T_MAX     = 7,
    parameter int CYC_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clk_en,
    input  logic                 i_rdy,
    input  logic                 i_rw,
    input  logic [TCU_WIDTH-1:0] i_tcu_next,
    input  logic                 i_done,
    input  logic                 i_nmi_n,
    input  logic                 i_irq_n,
    input  logic                 i_irq_mask,
    output logic [TCU_WIDTH-1:0] o_tcu,
    output logic                 o_sync,
    output logic                 o_stall,
    output logic                 o_jam,
    output logic                 o_int_nmi,
    output logic                 o_int_irq
`ifdef TCU_SEQUENCER_COUNTERS_EN
    ,
    output logic [CYC_WIDTH-1:0] o_cycle_count,
    output logic [CYC_WIDTH-1:0] o_instr_count
`endif
);

    localparam logic [TCU_WIDTH-1:0] TCU_RESET = TCU_WIDTH'(tcu_reset_value(TCU_WIDTH));
    localparam logic [TCU_WIDTH-1:0] T_MAX_V   = TCU_WIDTH'(T_MAX);

    if (T_MAX < 0 || T_MAX > (2 ** TCU_WIDTH) - 2 || CYC_WIDTH < 1) begin : g_param_check
        $error("tcu_sequencer: T_MAX or CYC_WIDTH out of range");
    end

    tcu_state_e           state_q;
    tcu_state_e           state_d;
    logic [TCU_WIDTH-1:0] tcu_q;
    logic [TCU_WIDTH-1:0] tcu_d;
    logic                 int_nmi_q;
    logic                 int_nmi_d;
    logic                 int_irq_q;
    logic                 int_irq_d;
    logic                 stall;
    logic                 advance;
    logic                 consume;
    logic                 nmi_pending;

    tcu_nmi_latch u_nmi_latch (
        .clk     (i_clk),
        .reset   (i_reset),
        .enable  (i_clk_en),
        .nmi_n   (i_nmi_n),
        .consume (consume),
        .pending (nmi_pending)
    );

    always_comb begin
        stall     = i_clk_en & ~i_rdy & i_rw & (state_q == ST_RUN);
        advance   = i_clk_en & ~stall & (state_q == ST_RUN);
        consume   = advance & i_done;
        state_d   = state_q;
        tcu_d     = tcu_q;
        int_nmi_d = int_nmi_q;
        int_irq_d = int_irq_q;
        case (state_q)
            ST_PRE: begin
                if (i_clk_en) begin
                    tcu_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    if (i_done) begin
                        tcu_d     = '0;
                        int_nmi_d = nmi_pending;
                        int_irq_d = ~i_irq_n & ~i_irq_mask & ~nmi_pending;
                    end else if (i_tcu_next > T_MAX_V) begin
                        // Illegal decode: freeze on the last good T-state until reset.
                        state_d = ST_JAM;
                    end else begin
                        tcu_d = i_tcu_next;
                    end
                end
            end
            ST_JAM:  state_d = ST_JAM;
            default: state_d = ST_PRE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_PRE;
            tcu_q     <= TCU_RESET;
            int_nmi_q <= 1'b0;
            int_irq_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcu_q     <= tcu_d;
            int_nmi_q <= int_nmi_d;
            int_irq_q <= int_irq_d;
        end
    end

    assign o_tcu     = tcu_q;
    assign o_sync    = (tcu_q == '0) & (state_q == ST_RUN);
    assign o_stall   = stall;
    assign o_jam     = (state_q == ST_JAM);
    assign o_int_nmi = int_nmi_q;
    assign o_int_irq = int_irq_q;

`ifdef TCU_SEQUENCER_COUNTERS_EN
    logic [CYC_WIDTH-1:0] cycle_count_q;
    logic [CYC_WIDTH-1:0] cycle_count_d;
    logic [CYC_WIDTH-1:0] instr_count_q;
    logic [CYC_WIDTH-1:0] instr_count_d;

    always_comb begin
        cycle_count_d = cycle_count_q;
        instr_count_d = instr_count_q;
        if (i_clk_en && (state_q == ST_RUN)) begin
            cycle_count_d = cycle_count_q + 1'b1;
        end
        if (consume) begin
            instr_count_d = instr_count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cycle_count_q <= '0;
            instr_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign o_cycle_count = cycle_count_q;
    assign o_instr_count = instr_count_q;
`endif

endmodule
